interpolator: RTL

//  Rate expander for the CIC interpolation path, the counterpart of the decimator.

---
 rtl/interpolator_pkg.sv | 14 +
 rtl/interpolator_if.sv | 25 ++
 rtl/interpolator_phase_counter.sv | 33 +++
 rtl/interpolator.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/interpolator_pkg.sv
// Shared types and elaboration helpers for the CIC rate-change blocks.
// Used by the interpolator and intended to be shared with the decimator.
package interpolator_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } interp_state_t;

  function automatic bit is_pow2(input int value);
    return (value > 32'sd0) && ((value & (value - 32'sd1)) == 32'sd0);
  endfunction

endpackage

// File: rtl/interpolator_if.sv
// Low-rate valid/ready input and high-rate output bundle of the interpolator.
interface interpolator_if #(
  parameter int WIDTH       = 1,
  parameter int INTERP_RATE = 4
);
  localparam int PW = $clog2(INTERP_RATE);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic [PW-1:0]    out_phase;
  logic             underrun;

  modport slave (
    input  in_data, in_valid,
    output in_ready, out_data, out_valid, out_phase, underrun
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, out_data, out_valid, out_phase, underrun
  );
endinterface

// File: rtl/interpolator_phase_counter.sv
// Free-running mod-RATE phase counter with terminal-count flag.
// RATE is a power of two, so the wrap is the natural binary overflow.
module phase_counter #(
  parameter int RATE = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      en,
  output logic [$clog2(RATE)-1:0]   cnt,
  output logic                      tc
);
  localparam int CW = $clog2(RATE);

  logic [CW-1:0] cnt_r;

  // phase count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (en) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;
  assign tc  = (cnt_r == CW'(RATE - 1));

endmodule

// File: rtl/interpolator.sv
// CIC interpolation rate expander: one low-rate sample per frame in, INTERP_RATE
// high-rate samples out (phase 0 carries the sample, other phases zero or hold).
module interpolator
  import interpolator_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int INTERP_RATE = 4,
  parameter bit ZERO_STUFF  = 1'b1
) (
  input logic           clk,
  input logic           rst,
  interpolator_if.slave bus
);
  localparam int PW = $clog2(INTERP_RATE);

  if (!is_pow2(INTERP_RATE) || (INTERP_RATE < 2)) begin : g_rate_check
    $error("interpolator: INTERP_RATE must be a power of 2 and at least 2");
  end

  interp_state_t    state_r;
  interp_state_t    state_nxt_s;
  logic [WIDTH-1:0] buf_r;
  logic [WIDTH-1:0] held_r;
  logic [WIDTH-1:0] out_data_r;
  logic [WIDTH-1:0] out_data_nxt_s;
  logic [WIDTH-1:0] stuff_s;
  logic             buf_full_r;
  logic             buf_full_nxt_s;
  logic             out_valid_r;
  logic             out_valid_nxt_s;
  logic             underrun_r;
  logic             underrun_nxt_s;
  logic             accept_s;
  logic             frame_start_s;
  logic             cnt_clr_s;
  logic             cnt_en_s;
  logic             tc_s;
  logic [PW-1:0]    cnt_s;

  // The buffer only accepts when empty and frame start only drains when full,
  // so a handshake and a frame start never touch the buffer in the same cycle.
  assign accept_s = bus.in_valid && !buf_full_r;
  assign stuff_s  = ZERO_STUFF ? {WIDTH{1'b0}} : held_r;

  phase_counter #(
    .RATE (INTERP_RATE)
  ) u_phase_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr_s),
    .en  (cnt_en_s),
    .cnt (cnt_s),
    .tc  (tc_s)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next state, counter control and next output values
  always_comb begin
    state_nxt_s     = state_r;
    frame_start_s   = 1'b0;
    cnt_clr_s       = 1'b0;
    cnt_en_s        = 1'b0;
    out_data_nxt_s  = out_data_r;
    out_valid_nxt_s = out_valid_r;
    underrun_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_clr_s = 1'b1;
        if (buf_full_r) begin
          state_nxt_s     = RUN;
          frame_start_s   = 1'b1;
          out_data_nxt_s  = buf_r;
          out_valid_nxt_s = 1'b1;
        end else begin
          out_data_nxt_s  = {WIDTH{1'b0}};
          out_valid_nxt_s = 1'b0;
        end
      end
      RUN: begin
        cnt_en_s        = 1'b1;
        out_valid_nxt_s = 1'b1;
        if (!tc_s) begin
          out_data_nxt_s = stuff_s;
        end else if (buf_full_r) begin
          frame_start_s  = 1'b1;
          out_data_nxt_s = buf_r;
        end else begin
          underrun_nxt_s = 1'b1;
          out_data_nxt_s = stuff_s;
        end
      end
      default: begin
        state_nxt_s     = IDLE;
        cnt_clr_s       = 1'b1;
        out_data_nxt_s  = {WIDTH{1'b0}};
        out_valid_nxt_s = 1'b0;
      end
    endcase
    if (accept_s) begin
      buf_full_nxt_s = 1'b1;
    end else if (frame_start_s) begin
      buf_full_nxt_s = 1'b0;
    end else begin
      buf_full_nxt_s = buf_full_r;
    end
  end

  // sample buffer, held sample and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_r       <= {WIDTH{1'b0}};
      buf_full_r  <= 1'b0;
      held_r      <= {WIDTH{1'b0}};
      out_data_r  <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      underrun_r  <= 1'b0;
    end else begin
      buf_full_r  <= buf_full_nxt_s;
      out_data_r  <= out_data_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      underrun_r  <= underrun_nxt_s;
      if (accept_s) begin
        buf_r <= bus.in_data;
      end
      if (frame_start_s) begin
        held_r <= buf_r;
      end
    end
  end

  assign bus.in_ready  = !buf_full_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_phase = cnt_s;
  assign bus.underrun  = underrun_r;

endmodule
